// File: rtl/idss_column_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : idss_column_feeder
//  Description : Front end of the 4-CSS input data shift structure (IDSS).
//                For each image column it accepts one 3-pixel column word per
//                input channel (4 channels) over a valid/ready stream. It
//                presents each word on row_1..3 and selects the target CSS
//                with LE_select. After the fourth word it issues a single
//                shift strobe. Once KERNEL_SIZE shifts have happened, it
//                flags each complete 3x3x4 window to the MAC array with a
//                valid/ready handshake. One start pulse processes one
//                3-row stripe of FEATURE_MAP_WIDTH columns.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        rising-edge clock
//    arst_n_in  in   1        asynchronous reset, active low
//    start      in   1        begin a stripe (accepted in IDLE only)
//    col_valid  in   1        column word valid
//    col_ready  out  1        feeder accepts a column word (LOAD only)
//    col_data   in   3*IODW   {row3,row2,row1}; channels 0..3 per column
//    row_1..3   out  IODW     pixels to the IDSS rows (registered)
//    LE_select  out  2        CSS being loaded (registered)
//    shift      out  1        one-cycle shift strobe to all CSS
//    win_valid  out  1        IDSS holds a complete window
//    win_ready  in   1        downstream takes the window
//    busy       out  1        stripe in progress
//    done       out  1        one-cycle pulse when the stripe finishes
// ============================================================================
module idss_column_feeder #(
    parameter int IO_DATA_WIDTH     = 16,
    parameter int FEATURE_MAP_WIDTH = 1024,
    parameter int KERNEL_SIZE       = 3
) (
    input  logic                       clk,
    input  logic                       arst_n_in,
    input  logic                       start,
    input  logic                       col_valid,
    output logic                       col_ready,
    input  logic [3*IO_DATA_WIDTH-1:0] col_data,
    output logic [IO_DATA_WIDTH-1:0]   row_1,
    output logic [IO_DATA_WIDTH-1:0]   row_2,
    output logic [IO_DATA_WIDTH-1:0]   row_3,
    output logic [1:0]                 LE_select,
    output logic                       shift,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       busy,
    output logic                       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1;
    localparam int SW = $clog2(KERNEL_SIZE + 1);

    localparam logic [CW-1:0] c_LAST_COL = CW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [SW-1:0] c_KERNEL   = SW'(KERNEL_SIZE);
    localparam logic [1:0]    c_LAST_CSS = 2'd3;

    // A stripe narrower than the kernel would never produce a window, and
    // DRAIN would wait forever for a transfer that cannot come.
    generate
        if (FEATURE_MAP_WIDTH < KERNEL_SIZE) begin : g_width_check
            $error("idss_column_feeder: FEATURE_MAP_WIDTH must be >= KERNEL_SIZE");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SHIFT  = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                   state_q;
    logic [1:0]               css_cnt_q;
    logic [CW-1:0]            col_cnt_q;
    logic [SW-1:0]            shift_cnt_q;
    logic [IO_DATA_WIDTH-1:0] row1_q;
    logic [IO_DATA_WIDTH-1:0] row2_q;
    logic [IO_DATA_WIDTH-1:0] row3_q;
    logic [1:0]               le_sel_q;
    logic                     shift_q;
    logic                     col_ready_q;
    logic                     win_valid_q;
    logic                     busy_q;
    logic                     done_q;

    // ------------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------------
    logic [CW-1:0] col_cnt_d;
    logic [SW-1:0] shift_cnt_d;
    logic          win_xfer;
    logic          col_hs;

    always_comb begin
        col_cnt_d   = col_cnt_q + CW'(1);
        // Saturate once the kernel is full; from then on every shift
        // produces a fresh window.
        shift_cnt_d = (shift_cnt_q >= c_KERNEL) ? shift_cnt_q
                                                : shift_cnt_q + SW'(1);
    end

    assign win_xfer = win_valid_q & win_ready;
    // col_ready_q is only ever high in LOAD, so this is also a LOAD qualifier.
    assign col_hs   = col_valid & col_ready_q;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= S_IDLE;
            css_cnt_q   <= 2'd0;
            col_cnt_q   <= '0;
            shift_cnt_q <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            row3_q      <= '0;
            le_sel_q    <= 2'd0;
            shift_q     <= 1'b0;
            col_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A transfer retires the window in any state. A set in SHIFT is
            // written later in this block and therefore takes priority.
            if (win_xfer) begin
                win_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        css_cnt_q   <= 2'd0;
                        col_cnt_q   <= '0;
                        shift_cnt_q <= '0;
                        col_ready_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // The selected CSS captures row_* one edge after this
                    // handshake. Without a handshake, it keeps re-capturing
                    // the same word.
                    if (col_hs) begin
                        row1_q   <= col_data[IO_DATA_WIDTH-1:0];
                        row2_q   <= col_data[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
                        row3_q   <= col_data[3*IO_DATA_WIDTH-1:2*IO_DATA_WIDTH];
                        le_sel_q <= css_cnt_q;
                        if (css_cnt_q == c_LAST_CSS) begin
                            col_ready_q <= 1'b0;
                            state_q     <= S_SETTLE;
                        end else begin
                            css_cnt_q <= css_cnt_q + 2'd1;
                        end
                    end
                end

                S_SETTLE: begin
                    // CSS3 captures its word during this cycle. Hold here
                    // while an unconsumed window is still in the IDSS; a
                    // shift now would destroy it.
                    if (!win_valid_q || win_ready) begin
                        shift_q <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    shift_q     <= 1'b0;
                    col_cnt_q   <= col_cnt_d;
                    shift_cnt_q <= shift_cnt_d;
                    if (shift_cnt_d >= c_KERNEL) begin
                        win_valid_q <= 1'b1;
                    end
                    if (col_cnt_q == c_LAST_COL) begin
                        state_q <= S_DRAIN;
                    end else begin
                        css_cnt_q   <= 2'd0;
                        col_ready_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end

                S_DRAIN: begin
                    // The last shift always raises win_valid, because the
                    // stripe width is at least the kernel width.
                    if (win_xfer) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    shift_q     <= 1'b0;
                    col_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign row_1     = row1_q;
    assign row_2     = row2_q;
    assign row_3     = row3_q;
    assign LE_select = le_sel_q;
    assign shift     = shift_q;
    assign col_ready = col_ready_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_idss_column_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idss_column_feeder
//  Description : Self-checking bench for idss_column_feeder. It models the
//                4-CSS shift structure behaviourally and checks every
//                consumed window against the column words that were sent.
//                Expected cycle timing is derived arithmetically from the
//                6-cycle column period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idss_column_feeder;

    localparam int DW = 16;
    localparam int W  = 5;
    localparam int K  = 3;
    localparam int W3 = 3;

    // ---------------- main DUT (W = 5) ----------------
    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          col_valid;
    logic          col_ready;
    logic [3*DW-1:0] col_data;
    logic [DW-1:0] row_1, row_2, row_3;
    logic [1:0]    LE_select;
    logic          shift;
    logic          win_valid;
    logic          win_ready;
    logic          busy;
    logic          done;

    // ---------------- minimum-width DUT (W = 3) ----------------
    logic          start3;
    logic          col_valid3;
    logic          col_ready3;
    logic [3*DW-1:0] col_data3;
    logic [DW-1:0] r1_3, r2_3, r3_3;
    logic [1:0]    le_3;
    logic          shift3;
    logic          win_valid3;
    logic          win_ready3;
    logic          busy3;
    logic          done3;

    idss_column_feeder #(.IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .KERNEL_SIZE(K)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
        .row_1(row_1), .row_2(row_2), .row_3(row_3), .LE_select(LE_select),
        .shift(shift), .win_valid(win_valid), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    idss_column_feeder #(.IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W3), .KERNEL_SIZE(K)) dut3 (
        .clk(clk), .arst_n_in(arst_n_in), .start(start3),
        .col_valid(col_valid3), .col_ready(col_ready3), .col_data(col_data3),
        .row_1(r1_3), .row_2(r2_3), .row_3(r3_3), .LE_select(le_3),
        .shift(shift3), .win_valid(win_valid3), .win_ready(win_ready3),
        .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;        // column handshakes in the current stripe
    int win_cnt = 0;       // windows consumed in the current stripe
    int w3_cnt = 0;
    int w3_xfer_cyc = 0;

    logic [3*DW-1:0] words [4*W];          // words[col*4 + ch]
    logic [3*DW-1:0] stage [4];            // CSS input latch
    logic [3*DW-1:0] idss  [4][3];         // [ch][0 = oldest column]
    logic [3*DW-1:0] snap  [4][3];

    assign col_data = words[hs_cnt % (4*W)];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural IDSS: each CSS latches row_* while selected; shift moves
    // the latched column into the 3-column window.
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (LE_select == 2'(c)) stage[c] <= {row_3, row_2, row_1};
            if (shift) begin
                idss[c][0] <= idss[c][1];
                idss[c][1] <= idss[c][2];
                idss[c][2] <= stage[c];
            end
        end
    end

    // Stream counters, reset when a stripe is accepted.
    always @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            hs_cnt  <= 0;
            win_cnt <= 0;
        end else if (start && !busy) begin
            hs_cnt  <= 0;
            win_cnt <= 0;
        end else begin
            if (col_valid && col_ready) hs_cnt <= hs_cnt + 1;
            if (win_valid && win_ready) win_cnt <= win_cnt + 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (win_valid3 && win_ready3) begin
            w3_cnt      <= w3_cnt + 1;
            w3_xfer_cyc <= cyc + 1;
        end
    end

    // Window w must hold columns w, w+1, w+2 of every channel.
    always @(negedge clk) begin
        if (arst_n_in && win_valid && win_ready) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 3; j++)
                    check($sformatf("window%0d_ch%0d_col%0d", win_cnt, c, j),
                          64'(idss[c][j]), 64'(words[((win_cnt + j) * 4 + c) % (4*W)]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_words();
        for (int i = 0; i < 4*W; i++)
            words[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    task automatic start_stripe();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    initial begin
        int c0;
        int m;
        int n;
        arst_n_in  = 1'b1;
        start      = 1'b0;
        col_valid  = 1'b0;
        win_ready  = 1'b0;
        start3     = 1'b0;
        col_valid3 = 1'b1;
        win_ready3 = 1'b1;
        col_data3  = {16'($urandom), 16'($urandom), 16'($urandom)};
        fill_words();

        // ---------------- reset state ----------------
        #2 arst_n_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_row_1", 64'(row_1), 64'(0));
        check("rst_row_2", 64'(row_2), 64'(0));
        check("rst_row_3", 64'(row_3), 64'(0));
        check("rst_le", 64'(LE_select), 64'(0));
        check("rst_shift", 64'(shift), 64'(0));
        check("rst_col_ready", 64'(col_ready), 64'(0));
        check("rst_win_valid", 64'(win_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        @(negedge clk) arst_n_in = 1'b1;
        tick();

        // ---------------- full-rate stripe, cycle-exact ----------------
        col_valid = 1'b1;
        win_ready = 1'b1;
        start_stripe();                        // now in cycle 0 (first LOAD)
        for (int t = 0; t <= 32; t++) begin
            m = t % 6;
            check($sformatf("shift@%0d", t), 64'(shift), 64'((m == 5) && (t < 30)));
            check($sformatf("win_valid@%0d", t), 64'(win_valid),
                  64'((t >= 18) && (t <= 30) && (m == 0)));
            check($sformatf("col_ready@%0d", t), 64'(col_ready), 64'((t < 30) && (m < 4)));
            check($sformatf("done@%0d", t), 64'(done), 64'(t == 31));
            check($sformatf("busy@%0d", t), 64'(busy), 64'(t < 31));
            if (t >= 1)
                check($sformatf("le@%0d", t), 64'(LE_select),
                      64'(((t <= 30) && (m >= 1) && (m <= 4)) ? m - 1 : 3));
            tick();
        end
        check("full_windows", 64'(win_cnt), 64'(W - K + 1));

        // ---------------- col_valid gap at css_cnt = 1 ----------------
        fill_words();
        start_stripe();
        tick();                                // channel 0 taken at cycle 0
        col_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gap_le%0d", i), 64'(LE_select), 64'(0));
            check($sformatf("gap_row1_%0d", i), 64'(row_1), 64'(words[0][DW-1:0]));
            check($sformatf("gap_row3_%0d", i), 64'(row_3), 64'(words[0][3*DW-1:2*DW]));
            check($sformatf("gap_ready%0d", i), 64'(col_ready), 64'(1));
            tick();
        end
        col_valid = 1'b1;
        run_until_done("gap", 60);
        check("gap_windows", 64'(win_cnt), 64'(W - K + 1));
        check("gap_hs", 64'(hs_cnt), 64'(4 * W));
        tick();

        // ---------------- downstream stall after the first window ----------------
        fill_words();
        win_ready = 1'b0;
        start_stripe();
        n = 0;
        while (win_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("stall_first_window", 64'(win_valid), 64'(1));
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 3; j++) snap[c][j] = idss[c][j];
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall_shift%0d", i), 64'(shift), 64'(0));
            check($sformatf("stall_wv%0d", i), 64'(win_valid), 64'(1));
            tick();
        end
        check("stall_next_col_loaded", 64'(hs_cnt), 64'(16));
        check("stall_parked_ready", 64'(col_ready), 64'(0));
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 3; j++)
                check($sformatf("stall_idss_ch%0d_col%0d", c, j), 64'(idss[c][j]), 64'(snap[c][j]));
        win_ready = 1'b1;                      // transfer at end of this cycle
        tick();
        check("stall_release_shift", 64'(shift), 64'(1));
        check("stall_release_wv", 64'(win_valid), 64'(0));
        run_until_done("stall", 60);
        check("stall_windows", 64'(win_cnt), 64'(W - K + 1));
        tick();

        // ---------------- spurious start / col_valid in IDLE ----------------
        fill_words();
        c0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_ready%0d", i), 64'(col_ready), 64'(0));
            check($sformatf("idle_busy%0d", i), 64'(busy), 64'(0));
            tick();
        end
        check("idle_no_consume", 64'(hs_cnt), 64'(c0));
        start_stripe();
        c0 = cyc;
        tick();
        tick();
        start = 1'b1;                          // must be ignored in LOAD
        tick();
        start = 1'b0;
        check("restart_ignored_le", 64'(LE_select), 64'(2));
        run_until_done("restart", 60);
        check("restart_latency", 64'(cyc - c0), 64'(31));
        check("restart_windows", 64'(win_cnt), 64'(W - K + 1));
        tick();

        // ---------------- reset mid-LOAD at css_cnt = 2 ----------------
        fill_words();
        start_stripe();
        tick();
        tick();                                // channels 0 and 1 taken
        col_valid = 1'b0;
        check("pre_rst_le", 64'(LE_select), 64'(1));
        arst_n_in = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(col_ready), 64'(0));
        check("mid_rst_le", 64'(LE_select), 64'(0));
        check("mid_rst_row2", 64'(row_2), 64'(0));
        tick();
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_shift", 64'(shift), 64'(0));
        @(negedge clk) arst_n_in = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'(0));
        check("post_rst_no_done", 64'(done), 64'(0));
        col_valid = 1'b1;
        start_stripe();
        tick();
        check("post_rst_le0", 64'(LE_select), 64'(0));
        check("post_rst_row1", 64'(row_1), 64'(words[0][DW-1:0]));
        run_until_done("post_rst", 60);
        check("post_rst_windows", 64'(win_cnt), 64'(W - K + 1));
        tick();

        // ---------------- minimum width W = 3 ----------------
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        c0 = cyc;
        n = 0;
        while (done3 !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("w3_done_seen", 64'(done3), 64'(1));
        check("w3_windows", 64'(w3_cnt), 64'(1));
        check("w3_done_after_xfer", 64'(cyc), 64'(w3_xfer_cyc));
        check("w3_latency", 64'(cyc - c0), 64'(19));
        check("w3_busy_low", 64'(busy3), 64'(0));
        tick();
        check("w3_done_pulse", 64'(done3), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
